vga_console_writer: RTL

//  Producer side of the VGA text-plane write port (charWr/charWrFgColor/charWrBgColor/charWrCode/X/Y).

---
 rtl/vga_text_pkg.sv | 23 ++
 rtl/vga_blank_sweeper.sv | 55 +++++
 rtl/vga_console_writer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vga_text_pkg.sv
// Shared definitions for the VGA text-plane writer: grid widths,
// control codes and controller state encoding.
package vga_text_pkg;

    localparam int GRID_X_W = 6;
    localparam int GRID_Y_W = 5;

    localparam logic [7:0] CTRL_BS = 8'h08;
    localparam logic [7:0] CTRL_LF = 8'h0A;
    localparam logic [7:0] CTRL_FF = 8'h0C;
    localparam logic [7:0] CTRL_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLR_SCREEN = 2'd1,
        ST_CLR_ROW    = 2'd2
    } state_t;

    function automatic logic is_print(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/vga_blank_sweeper.sv
// Walks cell addresses one per cycle to blank either a single row
// or the whole screen (row-major) in a latched background colour.
module vga_blank_sweeper
    import vga_text_pkg::*;
#(
    parameter int COLS = 64,
    parameter int ROWS = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                full,
    input  logic [GRID_Y_W-1:0] row,
    input  logic [23:0]         bg,
    output logic                wr,
    output logic [GRID_X_W-1:0] x,
    output logic [GRID_Y_W-1:0] y,
    output logic [23:0]         color,
    output logic                done
);

    localparam logic [GRID_X_W-1:0] X_LAST = GRID_X_W'(COLS - 1);
    localparam logic [GRID_Y_W-1:0] Y_LAST = GRID_Y_W'(ROWS - 1);

    logic active;
    logic full_q;

    assign wr   = active;
    assign done = active && (x == X_LAST) && (!full_q || (y == Y_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            full_q <= 1'b0;
            x      <= '0;
            y      <= '0;
            color  <= '0;
        end else if (start) begin
            active <= 1'b1;
            full_q <= full;
            x      <= '0;
            y      <= full ? '0 : row;
            color  <= bg;
        end else if (active) begin
            if (x == X_LAST) begin
                x <= '0;
                if (done) active <= 1'b0;
                else      y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_console_writer.sv
// Byte-stream console front end for the VGA text plane: cursor
// tracking, control-code handling and registered cell writes.
module vga_console_writer
    import vga_text_pkg::*;
#(
    parameter int         COLS        = 64,
    parameter int         ROWS        = 24,
    parameter logic [7:0] BLANK_CODE  = 8'h00,
    parameter bit         CLEAR_ON_RS = 1'b1
) (
    input  logic                CLOCK_50,
    input  logic                resetN,
    input  logic                inValid,
    output logic                inReady,
    input  logic [7:0]          inData,
    input  logic [23:0]         fgColor,
    input  logic [23:0]         bgColor,
    input  logic                clearReq,
    output logic                busy,
    output logic [GRID_X_W-1:0] cursorX,
    output logic [GRID_Y_W-1:0] cursorY,
    output logic                charWr,
    output logic [23:0]         charWrFgColor,
    output logic [23:0]         charWrBgColor,
    output logic [7:0]          charWrCode,
    output logic [GRID_X_W-1:0] charWrX,
    output logic [GRID_Y_W-1:0] charWrY
);

    localparam logic [GRID_X_W-1:0] X_LAST = GRID_X_W'(COLS - 1);
    localparam logic [GRID_Y_W-1:0] Y_LAST = GRID_Y_W'(ROWS - 1);

    state_t state, state_nxt;
    logic   init_pend;
    logic   accept, printable, at_edge;
    logic   [GRID_Y_W-1:0] y_adv;

    logic                sw_start, sw_full, sw_wr, sw_done;
    logic [23:0]         sw_bg, sw_color;
    logic [GRID_X_W-1:0] sw_x;
    logic [GRID_Y_W-1:0] sw_y;

    assign accept    = inValid && inReady;
    assign printable = is_print(inData);
    assign at_edge   = cursorX == X_LAST;
    assign y_adv     = (cursorY == Y_LAST) ? '0 : cursorY + 1'b1;

    always_ff @(posedge CLOCK_50 or negedge resetN) begin
        if (!resetN) begin
            state     <= ST_IDLE;
            init_pend <= CLEAR_ON_RS;
        end else begin
            state     <= state_nxt;
            init_pend <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (init_pend || clearReq)
                    state_nxt = ST_CLR_SCREEN;
                else if (accept && inData == CTRL_FF)
                    state_nxt = ST_CLR_SCREEN;
                else if (accept && (inData == CTRL_LF || (printable && at_edge)))
                    state_nxt = ST_CLR_ROW;
            end
            ST_CLR_SCREEN, ST_CLR_ROW: begin
                if (sw_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        inReady  = 1'b0;
        sw_start = 1'b0;
        sw_full  = 1'b0;
        sw_bg    = bgColor;
        unique case (state)
            ST_IDLE: begin
                inReady  = !clearReq && !init_pend;
                sw_start = state_nxt != ST_IDLE;
                sw_full  = state_nxt == ST_CLR_SCREEN;
                sw_bg    = init_pend ? 24'h0 : bgColor;
            end
            default: ;
        endcase
        busy = (state != ST_IDLE) || charWr;
    end

    vga_blank_sweeper #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_sweeper (
        .clk   (CLOCK_50),
        .rst_n (resetN),
        .start (sw_start),
        .full  (sw_full),
        .row   (y_adv),
        .bg    (sw_bg),
        .wr    (sw_wr),
        .x     (sw_x),
        .y     (sw_y),
        .color (sw_color),
        .done  (sw_done)
    );

    always_ff @(posedge CLOCK_50 or negedge resetN) begin
        if (!resetN) begin
            cursorX <= '0;
            cursorY <= '0;
        end else if (sw_start && sw_full) begin
            cursorX <= '0;
            cursorY <= '0;
        end else if (accept) begin
            unique case (1'b1)
                printable: begin
                    cursorX <= at_edge ? '0 : cursorX + 1'b1;
                    if (at_edge) cursorY <= y_adv;
                end
                inData == CTRL_LF: begin
                    cursorX <= '0;
                    cursorY <= y_adv;
                end
                inData == CTRL_CR: cursorX <= '0;
                inData == CTRL_BS: begin
                    if (cursorX != '0) cursorX <= cursorX - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sweeper writes and byte writes never coincide: bytes are only taken in IDLE.
    always_ff @(posedge CLOCK_50 or negedge resetN) begin
        if (!resetN) begin
            charWr        <= 1'b0;
            charWrFgColor <= '0;
            charWrBgColor <= '0;
            charWrCode    <= '0;
            charWrX       <= '0;
            charWrY       <= '0;
        end else begin
            charWr <= 1'b0;
            if (sw_wr) begin
                charWr        <= 1'b1;
                charWrFgColor <= sw_color;
                charWrBgColor <= sw_color;
                charWrCode    <= BLANK_CODE;
                charWrX       <= sw_x;
                charWrY       <= sw_y;
            end else if (accept && printable) begin
                charWr        <= 1'b1;
                charWrFgColor <= fgColor;
                charWrBgColor <= bgColor;
                charWrCode    <= inData;
                charWrX       <= cursorX;
                charWrY       <= cursorY;
            end else if (accept && inData == CTRL_BS && cursorX != '0) begin
                charWr        <= 1'b1;
                charWrFgColor <= fgColor;
                charWrBgColor <= bgColor;
                charWrCode    <= BLANK_CODE;
                charWrX       <= cursorX - 1'b1;
                charWrY       <= cursorY;
            end
        end
    end

endmodule
